// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types and widths for the ADC conversion sequencer
package adc_seq_pkg;

    localparam int ADC_RESULT_W = 16;
    localparam int ADC_CONFIG_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        GAP
    } seq_state_e;

endpackage

// File: rtl/adc_seq_fifo.sv
// rtl/adc_seq_fifo.sv - synchronous result FIFO, head shown combinationally from registers
module adc_seq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/adc_conversion_sequencer.sv
// rtl/adc_conversion_sequencer.sv - drives the ADC start/config handshake and queues results
module adc_conversion_sequencer
    import adc_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADC_CONFIG_W-1:0] cfg_config_1,
    input  logic [ADC_CONFIG_W-1:0] cfg_config_2,
    input  logic [15:0]             cfg_period,
    input  logic                    cfg_continuous,
    input  logic                    cmd_start,
    input  logic                    cmd_stop,
    input  logic                    clear_err,
    output logic                    start_conversion_out,
    output logic [ADC_CONFIG_W-1:0] config_1_out,
    output logic [ADC_CONFIG_W-1:0] config_2_out,
    input  logic [ADC_RESULT_W-1:0] result_in,
    input  logic                    conversion_finished_in,
    output logic [ADC_RESULT_W-1:0] data_out,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    busy,
    output logic                    overflow_err,
    output logic                    timeout_err
);

    localparam int MAXP = (SETUP_CYCLES > START_CYCLES) ? SETUP_CYCLES : START_CYCLES;
    localparam int PW   = $clog2(MAXP + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e              state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic                    cont_q, cont_d;
    logic [ADC_CONFIG_W-1:0] config_1_q, config_1_d;
    logic [ADC_CONFIG_W-1:0] config_2_q, config_2_d;
    logic [15:0]             period_cnt_q, period_cnt_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                    overflow_q, overflow_d;
    logic                    timeout_q, timeout_d;
    logic                    sync1_q, sync2_q, sync3_q;

    logic                    fin_rise;
    logic                    res_push;
    logic                    timeout_evt;
    logic                    period_done;
    logic [16:0]             period_sum;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ADC_RESULT_W-1:0] fifo_head;

    assign fin_rise = sync2_q & ~sync3_q;
    // Counter lags the start rise by one cycle and SETUP is still ahead, so both are added
    // back in to make rise-to-rise spacing equal cfg_period.
    assign period_sum  = {1'b0, period_cnt_q} + 17'(SETUP_CYCLES + 1);
    assign period_done = (period_sum >= {1'b0, cfg_period});

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cont_d       = cont_q;
        config_1_d   = config_1_q;
        config_2_d   = config_2_q;
        period_cnt_d = (period_cnt_q == 16'hFFFF) ? period_cnt_q : period_cnt_q + 16'd1;
        tmo_cnt_d    = tmo_cnt_q;
        res_push     = 1'b0;
        timeout_evt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    state_d    = SETUP;
                    phase_d    = '0;
                    config_1_d = cfg_config_1;
                    config_2_d = cfg_config_2;
                    cont_d     = cfg_continuous;
                end
            end
            SETUP: begin
                if (cmd_stop) cont_d = 1'b0;
                if (phase_q == PW'(SETUP_CYCLES - 1)) begin
                    state_d      = START;
                    phase_d      = '0;
                    period_cnt_d = '0;
                    tmo_cnt_d    = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            START: begin
                if (cmd_stop) cont_d = 1'b0;
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (phase_q == PW'(START_CYCLES - 1)) begin
                    state_d = WAIT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            WAIT: begin
                if (cmd_stop) cont_d = 1'b0;
                if (fin_rise) begin
                    res_push = 1'b1;
                    state_d  = (cont_q && !cmd_stop) ? GAP : IDLE;
                end else if (tmo_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_evt = 1'b1;
                    cont_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cmd_stop) begin
                    cont_d  = 1'b0;
                    state_d = IDLE;
                end else if (period_done) begin
                    state_d    = SETUP;
                    phase_d    = '0;
                    config_1_d = cfg_config_1;
                    config_2_d = cfg_config_2;
                end
            end
            default: state_d = IDLE;
        endcase
        overflow_d = (overflow_q & ~clear_err) | (res_push & fifo_full & ~fifo_pop);
        timeout_d  = (timeout_q & ~clear_err) | timeout_evt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            cont_q       <= 1'b0;
            config_1_q   <= '0;
            config_2_q   <= '0;
            period_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cont_q       <= cont_d;
            config_1_q   <= config_1_d;
            config_2_q   <= config_2_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            sync1_q      <= conversion_finished_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
        end
    end

    assign fifo_pop = data_valid & data_ready;

    adc_seq_fifo #(
        .WIDTH (ADC_RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (res_push),
        .push_data (result_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign start_conversion_out = (state_q == START);
    assign config_1_out         = config_1_q;
    assign config_2_out         = config_2_q;
    assign data_valid           = ~fifo_empty;
    // Stale storage is masked so the stream reads zero whenever nothing is queued.
    assign data_out             = data_valid ? fifo_head : '0;
    assign busy                 = (state_q != IDLE);
    assign overflow_err         = overflow_q;
    assign timeout_err          = timeout_q;

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// tb/tb_adc_conversion_sequencer.sv - directed self-checking bench for adc_conversion_sequencer
module tb_adc_conversion_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_config_1 = '0, cfg_config_2 = '0, cfg_period = '0;
    logic        cfg_continuous = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, clear_err = 1'b0;
    logic        start_conversion_out;
    logic [15:0] config_1_out, config_2_out;
    logic [15:0] result_in = '0;
    logic        conversion_finished_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        busy, overflow_err, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ADC model controls
    int          adc_lat = 20;
    logic [15:0] adc_res = '0;
    logic        adc_en = 1'b1;
    logic        fin_pulse = 1'b0;
    logic        fin_stuck = 1'b0;
    int          fin_at = -1, fin_off = -1;
    logic        start_d1 = 1'b0;
    int          rise_cyc [64];
    int          n_rise = 0;
    int          pop_count = 0;

    assign conversion_finished_in = fin_pulse | fin_stuck;

    adc_conversion_sequencer #(
        .FIFO_DEPTH     (4),
        .SETUP_CYCLES   (2),
        .START_CYCLES   (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cfg_config_1           (cfg_config_1),
        .cfg_config_2           (cfg_config_2),
        .cfg_period             (cfg_period),
        .cfg_continuous         (cfg_continuous),
        .cmd_start              (cmd_start),
        .cmd_stop               (cmd_stop),
        .clear_err              (clear_err),
        .start_conversion_out   (start_conversion_out),
        .config_1_out           (config_1_out),
        .config_2_out           (config_2_out),
        .result_in              (result_in),
        .conversion_finished_in (conversion_finished_in),
        .data_out               (data_out),
        .data_valid             (data_valid),
        .data_ready             (data_ready),
        .busy                   (busy),
        .overflow_err           (overflow_err),
        .timeout_err            (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: finished rises adc_lat cycles after a start rise, held for 4 cycles
    always @(negedge clk) begin
        if (start_conversion_out && !start_d1) begin
            if (n_rise < 64) rise_cyc[n_rise] = cyc;
            n_rise++;
            if (adc_en) fin_at = cyc + adc_lat;
        end
        start_d1 = start_conversion_out;
        if (cyc == fin_at) begin
            fin_pulse = 1'b1;
            result_in = adc_res;
            fin_off   = cyc + 4;
            fin_at    = -1;
        end else if (cyc == fin_off) begin
            fin_pulse = 1'b0;
            fin_off   = -1;
        end
        if (data_valid && data_ready) pop_count++;
    end

    typedef struct {
        logic [15:0] c1;
        logic [15:0] c2;
        logic [15:0] res;
        int          lat;
        logic [15:0] exp_c1;
        logic [15:0] exp_c2;
        logic [15:0] exp_data;
        int          exp_rel;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic launch(input logic [15:0] c1, input logic [15:0] c2, input logic cont,
                          output int n);
        cfg_config_1   = c1;
        cfg_config_2   = c2;
        cfg_continuous = cont;
        cmd_start      = 1'b1;
        n              = cyc + 1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic drain(input string name, input logic [15:0] first, input int cnt);
        data_ready = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            chk(name, data_out, first + 16'(i));
            @(negedge clk);
        end
        data_ready = 1'b0;
        chk({name, "_empty"}, data_valid, 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_start"}, start_conversion_out, 0);
        chk({name, "_cfg1"}, config_1_out, 0);
        chk({name, "_cfg2"}, config_2_out, 0);
        chk({name, "_valid"}, data_valid, 0);
        chk({name, "_data"}, data_out, 0);
        chk({name, "_ovf"}, overflow_err, 0);
        chk({name, "_tmo"}, timeout_err, 0);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n, r, base, pops0;
        vecs[0] = '{16'h1234, 16'hFEDC, 16'hBEEF, 0,  16'h1234, 16'hFEDC, 16'hBEEF, 5};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'h8001, 5,  16'h0000, 16'hFFFF, 16'h8001, 10};
        vecs[2] = '{16'hFFFF, 16'h0001, 16'h7FFE, 13, 16'hFFFF, 16'h0001, 16'h7FFE, 18};
        vecs[3] = '{16'hC3A5, 16'h0F0F, 16'h0000, 1,  16'hC3A5, 16'h0F0F, 16'h0000, 6};

        // reset state
        at(3);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // single-shot, cmd_start sampled at edge 10
        adc_lat = 20;
        adc_res = 16'h0123;
        at(9);
        launch(16'hA5C3, 16'h5A3C, 1'b0, n);
        chk("ss_cfg1", config_1_out, 16'hA5C3);
        chk("ss_cfg2", config_2_out, 16'h5A3C);
        chk("ss_busy", busy, 1);
        at(11); chk("ss_start11", start_conversion_out, 0);
        at(12); chk("ss_start12", start_conversion_out, 1);
        at(13); chk("ss_start13", start_conversion_out, 1);
        at(14); chk("ss_start14", start_conversion_out, 0);
        at(34); chk("ss_valid34", data_valid, 0); chk("ss_busy34", busy, 1);
        at(35); chk("ss_valid35", data_valid, 1); chk("ss_data", data_out, 16'h0123);
        chk("ss_busy35", busy, 0);
        drain("ss_pop", 16'h0123, 1);

        // table of single-shot conversions
        for (int i = 0; i < 4; i++) begin
            at(cyc + 3);
            adc_lat = vecs[i].lat;
            adc_res = vecs[i].res;
            launch(vecs[i].c1, vecs[i].c2, 1'b0, n);
            chk($sformatf("vec%0d_cfg1", i), config_1_out, vecs[i].exp_c1);
            chk($sformatf("vec%0d_cfg2", i), config_2_out, vecs[i].exp_c2);
            at(n + vecs[i].exp_rel - 1);
            chk($sformatf("vec%0d_early", i), data_valid, 0);
            at(n + vecs[i].exp_rel);
            chk($sformatf("vec%0d_valid", i), data_valid, 1);
            chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            chk($sformatf("vec%0d_idle", i), busy, 0);
            drain($sformatf("vec%0d_pop", i), vecs[i].exp_data, 1);
        end

        // continuous mode, period 50, stop mid-WAIT of the third conversion
        at(cyc + 5);
        adc_lat    = 20;
        adc_res    = 16'h0C0C;
        cfg_period = 16'd50;
        data_ready = 1'b1;
        base       = n_rise;
        pops0      = pop_count;
        launch(16'h0101, 16'h0202, 1'b1, n);
        at(n + 112);
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
        at(n + 202);
        chk("cont_rises", n_rise - base, 3);
        chk("cont_rise0", rise_cyc[base], n + 2);
        chk("cont_gap1", rise_cyc[base + 1] - rise_cyc[base], 50);
        chk("cont_gap2", rise_cyc[base + 2] - rise_cyc[base + 1], 50);
        chk("cont_results", pop_count - pops0, 3);
        chk("cont_idle", busy, 0);
        data_ready = 1'b0;

        // overflow: 5 conversions into a 4-deep FIFO, clear_err coincides with the drop
        adc_lat = 3;
        for (int i = 1; i <= 5; i++) begin
            at(cyc + 3);
            adc_res = 16'(i);
            launch(16'h0, 16'h0, 1'b0, n);
            if (i == 5) begin
                at(n + 7); clear_err = 1'b1;
                at(n + 8); clear_err = 1'b0;
                chk("ovf_set", overflow_err, 1);
            end else begin
                at(n + 8);
                chk($sformatf("ovf_clear%0d", i), overflow_err, 0);
            end
        end
        drain("ovf_keep", 16'd1, 4);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("ovf_cleared", overflow_err, 0);

        // full FIFO with simultaneous pop and push
        for (int i = 11; i <= 15; i++) begin
            at(cyc + 3);
            adc_res = 16'(i);
            launch(16'h0, 16'h0, 1'b0, n);
            if (i == 15) begin
                at(n + 7); data_ready = 1'b1;
                at(n + 8); data_ready = 1'b0;
            end else begin
                at(n + 8);
            end
        end
        chk("pp_no_ovf", overflow_err, 0);
        drain("pp_keep", 16'd12, 4);

        // timeout with a stale finished level held high
        adc_en    = 1'b0;
        fin_stuck = 1'b1;
        at(cyc + 5);
        launch(16'h0, 16'h0, 1'b0, n);
        r = n + 2;
        at(r + 99); chk("tmo_before", timeout_err, 0); chk("tmo_busy", busy, 1);
        at(r + 100); chk("tmo_set", timeout_err, 1); chk("tmo_idle", busy, 0);
        chk("tmo_nocapture", data_valid, 0);
        fin_stuck = 1'b0;
        adc_en    = 1'b1;

        // reset during WAIT with one result queued
        at(cyc + 5);
        adc_lat = 2;
        adc_res = 16'h5555;
        launch(16'h0, 16'h0, 1'b0, n);
        at(n + 7); chk("rst_pre_valid", data_valid, 1);
        at(cyc + 3);
        adc_lat = 20;
        launch(16'hAAAA, 16'hBBBB, 1'b0, n);
        r = n + 2;
        at(r + 10); rst_n = 1'b0;
        at(r + 11); rst_n = 1'b1;
        chk_all_zero("rst_mid");
        at(r + 30);
        chk("rst_nocap", data_valid, 0);
        chk("rst_idle", busy, 0);

        // concurrency: start+stop in IDLE, start and config change during WAIT
        base = n_rise;
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        chk("both_idle", busy, 0);
        at(cyc + 5);
        chk("both_norise", n_rise - base, 0);
        adc_res = 16'h9999;
        launch(16'h1111, 16'h2222, 1'b0, n);
        at(n + 7);
        cfg_config_1 = 16'hDEAD;
        cfg_config_2 = 16'hBEEF;
        cmd_start    = 1'b1;
        at(n + 8);
        cmd_start = 1'b0;
        chk("wait_cfg1", config_1_out, 16'h1111);
        chk("wait_cfg2", config_2_out, 16'h2222);
        chk("wait_busy", busy, 1);
        at(n + 25);
        chk("wait_valid", data_valid, 1);
        chk("wait_data", data_out, 16'h9999);
        at(n + 35);
        chk("wait_norelaunch", n_rise - base, 1);
        chk("wait_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
